inst_loader: RTL and testbench

//  Writer-side initiator for the 1-cycle-latency instruction/data memory. Accepts a valid/ready word

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/ld_checksum.sv | 34 +++
 rtl/inst_loader.sv | 171 +++++++++++++++++
 tb/tb_inst_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-port types and loader states.
// READBACK_VERIFY_EN adds the VERIFY state.
package mips_mem_pkg;

  localparam int unsigned MEM_DEPTH = 1024;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
`ifdef READBACK_VERIFY_EN
    VERIFY,
`endif
    DONE
  } loader_state_e;

endpackage

// File: rtl/ld_checksum.sv
// Clearable running sum that wraps modulo 2^W.
module ld_checksum #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         acc_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (acc_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign value_o = sum_q;

endmodule

// File: rtl/inst_loader.sv
// Streams words into consecutive memory addresses from base_addr, holding the CPU off the port.
// Optional readback checksum verify when READBACK_VERIFY_EN is defined.
module inst_loader
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned EW = ADDR_W + 1;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [10:0]       cnt_q, idx_q;
  logic              mem_we_q, error_q, done_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_wdata_q, wr_sum;
  logic [EW-1:0]     end_addr;
  logic              start_acc, hs, last_word, range_err;

  // Range check one bit wider than the address so a wrapping base cannot slip through.
  assign end_addr  = {1'b0, base_addr} + EW'(word_count);
  assign range_err = end_addr > EW'(DEPTH);
  // done_q marks the last busy cycle; a start there is still refused.
  assign start_acc = start && (state_q == IDLE) && !done_q;
  assign in_ready  = (state_q == LOAD);
  assign hs        = in_valid && in_ready;
  assign last_word = hs && (idx_q == cnt_q - 11'd1);

  ld_checksum #(.W(DATA_W)) u_wr_sum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_acc),
    .acc_i   (hs),
    .data_i  (in_data),
    .value_o (wr_sum)
  );

`ifdef READBACK_VERIFY_EN
  logic [10:0]       rcnt_q;
  logic              rv_a_q, rv_b_q, issue, verify_last, mismatch;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic [DATA_W-1:0] rb_sum;

  // rv_a: read address on the port; rv_b: its data on mem_rdata this cycle.
  assign issue       = (state_q == VERIFY) && (rcnt_q != cnt_q);
  assign verify_last = (state_q == VERIFY) && (rcnt_q == cnt_q) && !rv_a_q && rv_b_q;
  assign mismatch    = (rb_sum + mem_rdata) != wr_sum;

  ld_checksum #(.W(DATA_W)) u_rb_sum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_acc),
    .acc_i   (rv_b_q),
    .data_i  (mem_rdata),
    .value_o (rb_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= '0;
      rv_a_q      <= 1'b0;
      rv_b_q      <= 1'b0;
      mem_raddr_q <= '0;
    end else begin
      rv_a_q <= issue;
      rv_b_q <= rv_a_q;
      if (start_acc) begin
        rcnt_q <= '0;
      end else if (issue) begin
        mem_raddr_q <= base_q + ADDR_W'(rcnt_q);
        rcnt_q      <= rcnt_q + 11'd1;
      end
    end
  end

  assign mem_raddr = mem_raddr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_raddr    = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          if (range_err || word_count == 11'd0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_word) state_d = FLUSH;
      end
`ifdef READBACK_VERIFY_EN
      FLUSH:  state_d = VERIFY;
      VERIFY: begin
        if (verify_last) state_d = DONE;
      end
`else
      FLUSH:  state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == DONE);
      mem_we_q <= hs;
      if (start_acc) begin
        base_q  <= base_addr;
        cnt_q   <= word_count;
        idx_q   <= '0;
        error_q <= range_err;
      end
      if (hs) begin
        mem_waddr_q <= base_q + ADDR_W'(idx_q);
        mem_wdata_q <= in_data;
        idx_q       <= idx_q + 11'd1;
      end
`ifdef READBACK_VERIFY_EN
      if (verify_last && mismatch) error_q <= 1'b1;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE) || done_q;
  assign done      = done_q;
  assign error     = error_q;
  assign checksum  = wr_sum;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of load vectors, write scoreboard, memory model.
// Define READBACK_VERIFY_EN for both bench and RTL to exercise the readback verify path.
`timescale 1ns/1ps
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] in_data = '0;
  logic [10:0] word_count = '0;
  logic        in_ready, mem_we, busy, done, error;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata, checksum;

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(1024), .DATA_W(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  // 1-cycle-latency memory model
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_raddr[9:0]];
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  typedef struct {
    logic [31:0]       base;
    logic [10:0]       cnt;
    logic [3:0][31:0]  w;
    int                gap_at;
    bit                exp_err;
    logic [31:0]       exp_ck;
  } vec_t;

  wr_t         sb[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int          nchecks = 0;
  int          nerrs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Every write on the port must match the oldest accepted word, one cycle after its handshake.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (mem_we) begin
      if (sb.size() == 0) begin
        nchecks++;
        nerrs++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_waddr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_waddr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_latency", cyc, e.cyc + 1);
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] base, input logic [10:0] cnt,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int gap, input bit err, input logic [31:0] ck);
    vec_t v;
    v.base = base; v.cnt = cnt;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.gap_at = gap; v.exp_err = err; v.exp_ck = ck;
    return v;
  endfunction

  task automatic send_word(input logic [31:0] a, input logic [31:0] w, output int unsigned hs_cyc);
    bit ok;
    ok = 1'b0;
    hs_cyc = 0;
    in_valid = 1'b1;
    in_data = w;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{addr: a, data: w, cyc: cyc});
        hs_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("handshake", 32'(ok), 32'd1);
  endtask

  task automatic do_start(input logic [31:0] base, input logic [10:0] cnt, output int unsigned s_cyc);
    start = 1'b1;
    base_addr = base;
    word_count = cnt;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int unsigned dcyc);
    bit got;
    got = 1'b0;
    dcyc = 0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned s_cyc, first_hs, hcyc, dcyc;
    logic [31:0] a;
    done_cnt = 0;
    first_hs = 0;
    do_start(v.base, v.cnt, s_cyc);
    if (v.exp_err || v.cnt == 11'd0) begin
      in_valid = 1'b1;
      in_data = 32'hBAD0BAD0;
    end else begin
      for (int k = 0; k < int'(v.cnt); k++) begin
        send_word(v.base + 32'(k), v.w[k], hcyc);
        if (k == 0) first_hs = hcyc;
        if (k == v.gap_at) begin
          // stray start mid-load must be ignored
          start = 1'b1;
          base_addr = 32'd900;
          @(posedge clk); #1;
          start = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    wait_done(dcyc);
    in_valid = 1'b0;
    chk("error_at_done", 32'(error), 32'(v.exp_err));
    chk("checksum", checksum, v.exp_ck);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("in_ready_at_done", 32'(in_ready), 32'd0);
    if (v.exp_err || v.cnt == 11'd0) begin
      chk("done_latency_nowrite", dcyc, s_cyc + 2);
    end
`ifndef READBACK_VERIFY_EN
    else if (v.gap_at < 0) begin
      chk("done_latency_stream", dcyc, first_hs + 32'(v.cnt) + 2);
    end
`endif
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("error_sticky", 32'(error), 32'(v.exp_err));
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    if (!v.exp_err) begin
      for (int k = 0; k < int'(v.cnt); k++) begin
        a = v.base + 32'(k);
        chk("mem_contents", mem[a[9:0]], v.w[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    int unsigned s_cyc, hcyc, dcyc;

    vecs[0] = mk(32'd0,    11'd3, 32'h20, 32'h1, 32'h5, 32'h0, -1, 1'b0, 32'h26);
    vecs[1] = mk(32'd0,    11'd3, 32'h20, 32'h1, 32'h5, 32'h0,  0, 1'b0, 32'h26);
    vecs[2] = mk(32'd1020, 11'd5, 32'h0,  32'h0, 32'h0, 32'h0, -1, 1'b1, 32'h0);
    vecs[3] = mk(32'd10,   11'd0, 32'h0,  32'h0, 32'h0, 32'h0, -1, 1'b0, 32'h0);
    vecs[4] = mk(32'd1020, 11'd4, 32'hFFFFFFFF, 32'h2, 32'h3, 32'h4, -1, 1'b0, 32'h8);
    vecs[5] = mk(32'd1021, 11'd4, 32'h0,  32'h0, 32'h0, 32'h0, -1, 1'b1, 32'h0);
    vecs[6] = mk(32'd500,  11'd1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, -1, 1'b0, 32'hDEADBEEF);
    vecs[7] = mk(32'd600,  11'd4, 32'h1,  32'h2, 32'h3, 32'h4,  2, 1'b0, 32'hA);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_waddr", mem_waddr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // in_valid while idle must not be consumed
    in_valid = 1'b1;
    in_data = 32'h12345678;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifdef READBACK_VERIFY_EN
    // Corrupt a stored word after the final write commits; readback must flag it.
    done_cnt = 0;
    do_start(32'd100, 11'd3, s_cyc);
    send_word(32'd100, 32'h11, hcyc);
    send_word(32'd101, 32'h22, hcyc);
    send_word(32'd102, 32'h33, hcyc);
    @(posedge clk); #1;
    mem[101] = ~mem[101];
    wait_done(dcyc);
    chk("verify_error", 32'(error), 32'd1);
    chk("verify_checksum", checksum, 32'h66);
    repeat (3) @(negedge clk);
    chk("verify_sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
`endif

    // Reset mid-load after 2 of 4 words, then a normal load.
    do_start(32'd200, 11'd4, s_cyc);
    send_word(32'd200, 32'hA0, hcyc);
    send_word(32'd201, 32'hA1, hcyc);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_checksum", checksum, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0]);
    chk("abort_partial_0", mem[200], 32'hA0);
    chk("abort_partial_1", mem[201], 32'hA1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
